// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte input and a one-entry
// holding register so consecutive frames can go out without an idle gap.
module uart_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_tx_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic          stop_q, stop_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;

    logic tick;
    logic accept;
    logic direct;

    assign tick   = (baud_q == BAUD_LAST);
    assign accept = i_valid && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        done_d      = 1'b0;
        direct      = 1'b0;
        tx_d        = 1'b1;
        if (state_q == IDLE || tick) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = START;
                end else if (accept) begin
                    shift_d = i_data;
                    direct  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        stop_d  = 1'b0;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_q == STOP_LAST) begin
                        done_d = 1'b1;
                        // Chain straight into the next frame when a byte is available.
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            state_d     = START;
                        end else if (accept) begin
                            shift_d = i_data;
                            direct  = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
        endcase

        if (accept && !direct) begin
            hold_d      = i_data;
            hold_full_d = 1'b1;
        end

        unique case (state_d)
            IDLE:  tx_d = 1'b1;
            START: tx_d = 1'b0;
            DATA:  tx_d = shift_d[0];
            STOP:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            baud_q      <= '0;
            bit_q       <= '0;
            stop_q      <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end

    assign o_ready   = !hold_full_q;
    assign o_busy    = (state_q != IDLE);
    assign o_tx      = tx_q;
    assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (default timing and 4 clk/bit, 2 stop),
// a line-decoding monitor per instance and a byte scoreboard.
module tb_uart_tx;

    logic       clk;
    logic       rst_n, valid, ready, tx, busy, done;
    logic [7:0] data;
    logic       rst_n_b, valid_b, ready_b, tx_b, busy_b, done_b;
    logic [7:0] data_b;

    uart_tx dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
        .o_ready(ready), .o_tx(tx), .o_busy(busy), .o_tx_done(done)
    );

    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n_b), .i_valid(valid_b), .i_data(data_b),
        .o_ready(ready_b), .o_tx(tx_b), .o_busy(busy_b), .o_tx_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int gen[2];
    int pops[2];

    logic log_a[$];
    logic log_b[$];
    logic log_en_a = 1'b0;
    logic log_en_b = 1'b0;
    int busy_a = 0, busy_b_cnt = 0;
    int done_a = 0, done_b_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic line(input int w);
        return (w == 0) ? tx : tx_b;
    endfunction

    function automatic logic rdy(input int w);
        return (w == 0) ? ready : ready_b;
    endfunction

    // Reference frame: bit i of an 8N1 frame, any index past the data is stop/idle high.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (log_en_a) begin
                log_a.push_back(tx);
                if (busy === 1'b1) busy_a++;
            end
            if (log_en_b) begin
                log_b.push_back(tx_b);
                if (busy_b === 1'b1) busy_b_cnt++;
            end
            if (done === 1'b1) done_a++;
            if (done_b === 1'b1) done_b_cnt++;
        end
    end

    task automatic monitor(input int w, input int cpb);
        logic [7:0] d;
        logic [7:0] e;
        int g;
        int qs;
        forever begin
            @(negedge clk);
            if (line(w) === 1'b0) begin
                g = gen[w];
                repeat (cpb / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (cpb) @(negedge clk);
                    d[i] = line(w);
                end
                repeat (cpb) @(negedge clk);
                if (gen[w] == g) begin
                    chk("stop_bit", int'(line(w)), 1);
                    qs = (w == 0) ? exp_a.size() : exp_b.size();
                    chk("frame_has_expected_byte", int'(qs > 0), 1);
                    if (qs > 0) begin
                        e = (w == 0) ? exp_a.pop_front() : exp_b.pop_front();
                        pops[w]++;
                        chk("rx_byte", int'(d), int'(e));
                    end
                end
            end
        end
    endtask

    initial monitor(0, 1);
    initial monitor(1, 4);

    task automatic set_valid(input int w, input logic v);
        if (w == 0) valid = v;
        else valid_b = v;
    endtask

    task automatic send(input int w, input logic [7:0] b, output int acc);
        int n;
        n = 0;
        if (w == 0) begin valid = 1'b1; data = b; end
        else begin valid_b = 1'b1; data_b = b; end
        while (!rdy(w) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy(w)) begin
            chk("accept_timeout", int'(rdy(w)), 1);
            set_valid(w, 1'b0);
            acc = -1;
            return;
        end
        @(posedge clk);
        acc = int'($time / 10);
        if (w == 0) exp_a.push_back(b);
        else exp_b.push_back(b);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_log(input int w);
        if (w == 0) begin log_a.delete(); busy_a = 0; log_en_a = 1'b1; end
        else begin log_b.delete(); busy_b_cnt = 0; log_en_b = 1'b1; end
    endtask

    task automatic check_log(input int w, input logic [7:0] b0, input logic [7:0] b1,
                             input int nfr, input int cpb, input int sb);
        logic q[$];
        int s;
        int flen;
        logic [7:0] b;
        q = (w == 0) ? log_a : log_b;
        if (w == 0) log_en_a = 1'b0;
        else log_en_b = 1'b0;
        s = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] === 1'b0 && s < 0) s = i;
        end
        chk("start_latency", s, 1);
        flen = (9 + sb) * cpb;
        chk("log_long_enough", int'(s >= 0 && q.size() > s + nfr * flen), 1);
        if (s >= 0 && q.size() > s + nfr * flen) begin
            for (int f = 0; f < nfr; f++) begin
                b = (f == 0) ? b0 : b1;
                for (int i = 0; i < flen; i++)
                    chk("line_bit", int'(q[s + f*flen + i]), int'(exp_bit(b, i / cpb)));
            end
            chk("line_idle_after", int'(q[s + nfr*flen]), 1);
        end
    endtask

    int a1, a2, a3, d0, zeros;
    logic [7:0] tbl[3];

    initial begin
        rst_n = 1'b0; rst_n_b = 1'b0;
        valid = 1'b0; valid_b = 1'b0;
        data = '0; data_b = '0;
        gen[0] = 0; gen[1] = 0; pops[0] = 0; pops[1] = 0;
        wait_cyc(3);
        rst_n = 1'b1; rst_n_b = 1'b1;
        @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_b_tx", int'(tx_b), 1);
        chk("rst_b_ready", int'(ready_b), 1);
        chk("rst_b_busy", int'(busy_b), 0);
        wait_cyc(1);

        // single byte
        d0 = done_a;
        start_log(0);
        send(0, 8'hA5, a1);
        valid = 1'b0;
        wait_cyc(14);
        check_log(0, 8'hA5, 8'h00, 1, 1, 1);
        chk("a5_busy_cycles", busy_a, 10);
        chk("a5_done_pulses", done_a - d0, 1);

        // loopback bytes
        d0 = done_a;
        tbl[0] = 8'h00; tbl[1] = 8'hFF; tbl[2] = 8'h3C;
        foreach (tbl[i]) begin
            send(0, tbl[i], a1);
            valid = 1'b0;
            wait_cyc(12);
        end
        chk("loop_done_pulses", done_a - d0, 3);

        // back-to-back with hold register
        d0 = done_a;
        start_log(0);
        send(0, 8'h55, a1);
        send(0, 8'hAA, a2);
        valid = 1'b0;
        chk("b2b_ready_low", int'(ready), 0);
        chk("b2b_accept_gap", a2 - a1, 1);
        wait_cyc(24);
        check_log(0, 8'h55, 8'hAA, 2, 1, 1);
        chk("b2b_busy_cycles", busy_a, 20);
        chk("b2b_done_pulses", done_a - d0, 2);

        // three bytes, valid held
        d0 = done_a;
        send(0, 8'h12, a1);
        send(0, 8'h34, a2);
        send(0, 8'h56, a3);
        valid = 1'b0;
        chk("three_third_accept", a3 - a1, 11);
        wait_cyc(35);
        chk("three_done_pulses", done_a - d0, 3);

        // reset during bit 4 with hold full
        d0 = done_a;
        send(0, 8'h5A, a1);
        send(0, 8'hC3, a2);
        valid = 1'b0;
        wait_cyc(4);
        rst_n = 1'b0;
        @(posedge clk);
        gen[0]++;
        exp_a.delete();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_tx", int'(tx), 1);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_ready", int'(ready), 1);
        wait_cyc(1);
        start_log(0);
        wait_cyc(30);
        log_en_a = 1'b0;
        zeros = 0;
        foreach (log_a[i]) if (log_a[i] !== 1'b1) zeros++;
        chk("rstmid_line_quiet", zeros, 0);
        chk("rstmid_busy_cycles", busy_a, 0);
        chk("rstmid_no_done", done_a - d0, 0);

        // reset wins over same-edge accept
        rst_n = 1'b0; valid = 1'b1; data = 8'h77;
        @(posedge clk);
        gen[0]++;
        #1;
        rst_n = 1'b1; valid = 1'b0;
        @(negedge clk);
        chk("rstprio_busy", int'(busy), 0);
        chk("rstprio_tx", int'(tx), 1);
        wait_cyc(15);

        // slow instance: 4 clocks per bit, 2 stop bits
        d0 = done_b_cnt;
        start_log(1);
        send(1, 8'h81, a1);
        valid_b = 1'b0;
        wait_cyc(50);
        check_log(1, 8'h81, 8'h00, 1, 4, 2);
        chk("b_busy_cycles", busy_b_cnt, 44);
        chk("b_done_pulses", done_b_cnt - d0, 1);

        // randomized traffic, gaps sometimes, valid sometimes held
        for (int k = 0; k < 20; k++) begin
            send(0, 8'($urandom), a1);
            if ($urandom_range(0, 1) == 1) begin
                valid = 1'b0;
                wait_cyc($urandom_range(0, 12));
            end
        end
        valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(1, 8'($urandom), a1);
            if ($urandom_range(0, 1) == 1) begin
                valid_b = 1'b0;
                wait_cyc($urandom_range(0, 40));
            end
        end
        valid_b = 1'b0;
        wait_cyc(120);

        chk("a_queue_drained", exp_a.size(), 0);
        chk("b_queue_drained", exp_b.size(), 0);
        chk("a_done_vs_frames", done_a, pops[0]);
        chk("b_done_vs_frames", done_b_cnt, pops[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_chk, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART link: accepts bytes over a valid/ready handshake and drives them on a single line as 8N1 frames (start bit 0, eight data bits LSB first, one or two stop bits 1). It is the transmit end matching the existing UART receiver, so a loopback of `o_tx` into that receiver's `i_din` returns the sent byte. A one-entry holding register allows gapless back-to-back frames.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles per bit period, minimum 1. The default of 1 matches the receiver's one-bit-per-clock sampling.
- `STOP_BITS`, default 1: number of stop-bit periods, 1 or 2.
- `i_clk`, input, 1: sole clock; all logic on the rising edge.
- `i_rst_n`, input, 1: synchronous, active-low reset.
- `i_valid`, input, 1: `i_data` holds a byte to send.
- `i_data`, input, 8: byte to transmit; sampled only on an accept edge.
- `o_ready`, output, 1: block can accept a byte; equals NOT hold_full.
- `o_tx`, output, 1: serial line, registered; idle high.
- `o_busy`, output, 1: high while the state is not IDLE.
- `o_tx_done`, output, 1: one-cycle pulse after the final stop bit of each frame.

## Operation
- Accept: `i_valid && o_ready` sampled at a rising edge.
- States:
  - IDLE: `o_tx`=1.
  - START: `o_tx`=0, one bit period.
  - DATA: `o_tx`=shift[0], right shift each period, 8 periods, bit counter 0..7.
  - STOP: `o_tx`=1, `STOP_BITS` periods.
- Baud counter: counts 0..`CLKS_PER_BIT`-1. A bit period ends at the edge where the counter equals `CLKS_PER_BIT`-1, and the counter wraps to 0. Width is clog2(`CLKS_PER_BIT`), minimum 1.
- Frame start from IDLE:
  - If IDLE and the hold register is empty, an accepted byte loads directly into the shifter and the state goes to START at that same edge.
  - If IDLE and the hold register is full, the shifter loads from hold at the next edge and the hold register empties.
- Accept while a frame is in flight: the byte goes into the hold register, `o_ready` deasserts, and the byte is not lost.
- Edge ending the last stop period:
  - Hold full: the shifter loads from hold and the state goes to START. There is no idle gap, and `o_ready` rises in the next cycle.
  - Hold empty with an accept on the same edge: the byte goes straight into the shifter and the state goes to START (gapless).
  - Otherwise: the state goes to IDLE.
- `o_tx_done` asserts for the cycle following the last stop-bit edge, including when the next frame starts gapless.
- `i_valid` while `o_ready`=0 is ignored; the source must hold the byte.

## Timing
- Reset values: `o_tx`=1, `o_ready`=1, `o_busy`=0, `o_tx_done`=0, state IDLE, hold empty, counters 0.
- Latency: accept at edge k with IDLE and hold empty gives `o_tx`=0 starting in the cycle after edge k.
- Frame length: (10 + `STOP_BITS` - 1) × `CLKS_PER_BIT` cycles.
  - Defaults: 10 cycles.
  - Back-to-back throughput: one byte per frame length.
- Reset mid-frame: on the reset edge, `o_tx` returns to 1 and both the in-flight byte and the held byte are discarded. No `o_tx_done` pulse is produced.
- Reset has priority over an accept on the same edge.
- `o_busy` is low only in IDLE. It stays high across gapless frames.

## Test plan
- Single byte 0xA5, defaults: after the accept edge, `o_tx` carries 0,1,0,1,0,0,1,0,1,1 over 10 cycles, then stays 1. `o_tx_done` pulses once, and `o_busy` is high for exactly 10 cycles.
- Loopback into the UART receiver with bytes 0x00, 0xFF, 0x3C: each byte sent yields a receiver `rx_done` with a matching `o_dout`.
- Back-to-back 0x55 then 0xAA, with `i_valid` held high: the second accept occurs during frame 1 and `o_ready` goes low. The 20 line cycles are contiguous with no idle-high gap between the stop bit and the next start bit, and `o_tx_done` pulses twice.
- `CLKS_PER_BIT`=4, `STOP_BITS`=2, byte 0x81: each bit lasts 4 cycles, the frame is 44 cycles, and the stop high lasts 8 cycles.
- Three bytes offered with `i_valid` held continuously: the third is accepted only after the hold register drains, and the bytes go out in order with none dropped or duplicated.
- Reset asserted in bit 4 of a frame with hold full: `o_tx`=1, `o_busy`=0 and `o_ready`=1 in the cycle after the reset edge. No frame follows until a new accept.
